matrix_slot_manager: RTL and testbench



---
 rtl/matrix_slot_manager.sv | 271 +++++++++++++++++++++++++++
 tb/tb_matrix_slot_manager.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_slot_manager.sv
// rtl/matrix_slot_manager.sv - matrix slot table: scan-based allocation, commit, registered lookup
// Optional eviction build: define MATRIX_MGR_EVICT_EN
`ifndef BRAM_ADDR_WIDTH
`define BRAM_ADDR_WIDTH 8
`endif

module matrix_slot_manager #(
  parameter int NUM_SLOTS  = 10,
  parameter int SLOT_DEPTH = 25,
  parameter int ADDR_WIDTH = `BRAM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            config_max_per_shape,
  input  logic                  alloc_req,
  input  logic [3:0]            alloc_m,
  input  logic [3:0]            alloc_n,
  output logic [3:0]            alloc_slot,
  output logic [ADDR_WIDTH-1:0] alloc_addr,
  output logic                  alloc_valid,
  output logic                  alloc_fail,
  input  logic                  commit_req,
  input  logic [3:0]            commit_slot,
  input  logic [3:0]            commit_m,
  input  logic [3:0]            commit_n,
  input  logic [ADDR_WIDTH-1:0] commit_addr,
  output logic                  commit_err,
  input  logic [3:0]            query_slot,
  output logic                  query_valid,
  output logic [3:0]            query_m,
  output logic [3:0]            query_n,
  output logic [ADDR_WIDTH-1:0] query_addr,
  output logic [3:0]            num_valid,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, SCAN, DECIDE} state_t;

  localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(SLOT_DEPTH);
  localparam logic [4:0]            SCAN_END = 5'(NUM_SLOTS);

  state_t                  state;
  logic [NUM_SLOTS-1:0]    ent_valid;
  logic [3:0]              ent_m [NUM_SLOTS];
  logic [3:0]              ent_n [NUM_SLOTS];
  logic                    armed;
  logic                    res_pending;
  logic [3:0]              res_slot, res_m, res_n;
  logic [ADDR_WIDTH-1:0]   res_addr;
  logic [3:0]              req_m, req_n;
  logic [4:0]              scan_idx;
  logic [ADDR_WIDTH-1:0]   scan_addr;
  logic [4:0]              shape_cnt;
  logic                    free_found;
  logic [3:0]              free_slot;
  logic [ADDR_WIDTH-1:0]   free_addr;

  logic [3:0]              scan_slot;
  logic                    scan_in_range, scan_same, start_scan, commit_ok, dims_bad;
  logic [4:0]              lim5;
  logic [3:0]              valid_cnt;
  logic                    dec_grant, dec_evict;
  logic [3:0]              dec_slot;
  logic [ADDR_WIDTH-1:0]   dec_addr;

  assign busy = (state != IDLE);

  // Per-cycle helpers: scan visit, commit match, shape limit, committed count
  always_comb begin
    scan_slot     = scan_idx[3:0];
    scan_in_range = (scan_idx < SCAN_END);
    scan_same     = scan_in_range && ent_valid[scan_slot] &&
                    (ent_m[scan_slot] == req_m) && (ent_n[scan_slot] == req_n);
    start_scan    = (state == IDLE) && alloc_req && armed;
    commit_ok     = res_pending && (commit_slot == res_slot) && (commit_m == res_m) &&
                    (commit_n == res_n) && (commit_addr == res_addr);
    lim5          = (config_max_per_shape == 4'd0) ? 5'd1 : {1'b0, config_max_per_shape};
    dims_bad      = (req_m == 4'd0) || (req_m > 4'd5) || (req_n == 4'd0) || (req_n > 4'd5);
    valid_cnt     = 4'd0;
    for (int i = 0; i < NUM_SLOTS; i++) valid_cnt = valid_cnt + 4'(ent_valid[i]);
  end

`ifdef MATRIX_MGR_EVICT_EN
  logic [7:0]              seq;
  logic [7:0]              ent_stamp [NUM_SLOTS];
  logic [7:0]              scan_age;
  logic                    same_found, old_found;
  logic [3:0]              same_slot, old_slot;
  logic [ADDR_WIDTH-1:0]   same_addr, old_addr;
  logic [7:0]              same_age, old_age;

  // Age of the visited slot; modular difference stays correct across seq wrap
  always_comb scan_age = seq - ent_stamp[scan_slot];

  // Commit stamping and oldest-victim tracking during the scan
  always_ff @(posedge clk) begin
    if (rst) begin
      seq        <= 8'd0;
      same_found <= 1'b0;
      old_found  <= 1'b0;
      same_slot  <= 4'd0;
      old_slot   <= 4'd0;
      same_addr  <= '0;
      old_addr   <= '0;
      same_age   <= 8'd0;
      old_age    <= 8'd0;
    end else begin
      if (commit_req && commit_ok) begin
        ent_stamp[commit_slot] <= seq;
        seq                    <= seq + 8'd1;
      end
      if (start_scan) begin
        same_found <= 1'b0;
        old_found  <= 1'b0;
      end else if (state == SCAN && scan_in_range) begin
        if (scan_same && (!same_found || scan_age > same_age)) begin
          same_found <= 1'b1;
          same_slot  <= scan_slot;
          same_addr  <= scan_addr;
          same_age   <= scan_age;
        end
        if (ent_valid[scan_slot] && (!old_found || scan_age > old_age)) begin
          old_found <= 1'b1;
          old_slot  <= scan_slot;
          old_addr  <= scan_addr;
          old_age   <= scan_age;
        end
      end
    end
  end
`endif

  // Allocation decision from the accumulated scan results
  always_comb begin
    dec_grant = 1'b0;
    dec_evict = 1'b0;
    dec_slot  = free_slot;
    dec_addr  = free_addr;
    if (!dims_bad) begin
      if (shape_cnt < lim5 && free_found) begin
        dec_grant = 1'b1;
      end
`ifdef MATRIX_MGR_EVICT_EN
      else if (shape_cnt >= lim5) begin
        dec_grant = 1'b1;
        dec_evict = 1'b1;
        dec_slot  = same_slot;
        dec_addr  = same_addr;
      end else begin
        dec_grant = 1'b1;
        dec_evict = 1'b1;
        dec_slot  = old_slot;
        dec_addr  = old_addr;
      end
`endif
    end
  end

  // Allocation FSM, table updates, commit checking and registered lookup
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      armed       <= 1'b1;
      res_pending <= 1'b0;
      res_slot    <= 4'd0;
      res_m       <= 4'd0;
      res_n       <= 4'd0;
      res_addr    <= '0;
      req_m       <= 4'd0;
      req_n       <= 4'd0;
      scan_idx    <= 5'd0;
      scan_addr   <= '0;
      shape_cnt   <= 5'd0;
      free_found  <= 1'b0;
      free_slot   <= 4'd0;
      free_addr   <= '0;
      alloc_slot  <= 4'd0;
      alloc_addr  <= '0;
      alloc_valid <= 1'b0;
      alloc_fail  <= 1'b0;
      commit_err  <= 1'b0;
      query_valid <= 1'b0;
      query_m     <= 4'd0;
      query_n     <= 4'd0;
      query_addr  <= '0;
      num_valid   <= 4'd0;
      ent_valid   <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        ent_m[i] <= 4'd0;
        ent_n[i] <= 4'd0;
      end
    end else begin
      alloc_valid <= 1'b0;
      alloc_fail  <= 1'b0;
      commit_err  <= 1'b0;
      num_valid   <= valid_cnt;

      if ({1'b0, query_slot} < SCAN_END) begin
        query_valid <= ent_valid[query_slot];
        query_m     <= ent_m[query_slot];
        query_n     <= ent_n[query_slot];
        query_addr  <= ADDR_WIDTH'(query_slot * SLOT_DEPTH);
      end else begin
        query_valid <= 1'b0;
        query_m     <= 4'd0;
        query_n     <= 4'd0;
        query_addr  <= '0;
      end

      if (commit_req) begin
        if (commit_ok) begin
          ent_valid[commit_slot] <= 1'b1;
          ent_m[commit_slot]     <= commit_m;
          ent_n[commit_slot]     <= commit_n;
          res_pending            <= 1'b0;
        end else begin
          commit_err <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (start_scan) begin
            req_m       <= alloc_m;
            req_n       <= alloc_n;
            res_pending <= 1'b0;
            armed       <= 1'b0;
            scan_idx    <= 5'd0;
            scan_addr   <= '0;
            shape_cnt   <= 5'd0;
            free_found  <= 1'b0;
            state       <= SCAN;
          end else if (!alloc_req) begin
            armed <= 1'b1;
          end
        end
        SCAN: begin
          // One extra cycle after the last slot lets the final accumulation settle
          if (scan_in_range) begin
            if (scan_same) shape_cnt <= shape_cnt + 5'd1;
            if (!ent_valid[scan_slot] && !free_found) begin
              free_found <= 1'b1;
              free_slot  <= scan_slot;
              free_addr  <= scan_addr;
            end
            scan_idx  <= scan_idx + 5'd1;
            scan_addr <= scan_addr + DEPTH_A;
          end else begin
            state <= DECIDE;
          end
        end
        DECIDE: begin
          if (dec_grant) begin
            if (dec_evict) ent_valid[dec_slot] <= 1'b0;
            alloc_valid <= 1'b1;
            alloc_slot  <= dec_slot;
            alloc_addr  <= dec_addr;
            res_pending <= 1'b1;
            res_slot    <= dec_slot;
            res_m       <= req_m;
            res_n       <= req_n;
            res_addr    <= dec_addr;
          end else begin
            alloc_fail <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_slot_manager.sv
// tb/tb_matrix_slot_manager.sv - directed scoreboard bench for matrix_slot_manager
`timescale 1ns/1ps
module tb_matrix_slot_manager;
  localparam int NS = 10;
  localparam int SD = 25;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    config_max_per_shape;
  logic          alloc_req;
  logic [3:0]    alloc_m, alloc_n;
  logic [3:0]    alloc_slot;
  logic [AW-1:0] alloc_addr;
  logic          alloc_valid, alloc_fail;
  logic          commit_req;
  logic [3:0]    commit_slot, commit_m, commit_n;
  logic [AW-1:0] commit_addr;
  logic          commit_err;
  logic [3:0]    query_slot;
  logic          query_valid;
  logic [3:0]    query_m, query_n;
  logic [AW-1:0] query_addr;
  logic [3:0]    num_valid;
  logic          busy;

  always #5 clk = ~clk;

  matrix_slot_manager #(.NUM_SLOTS(NS), .SLOT_DEPTH(SD), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .config_max_per_shape(config_max_per_shape),
    .alloc_req(alloc_req), .alloc_m(alloc_m), .alloc_n(alloc_n),
    .alloc_slot(alloc_slot), .alloc_addr(alloc_addr),
    .alloc_valid(alloc_valid), .alloc_fail(alloc_fail),
    .commit_req(commit_req), .commit_slot(commit_slot), .commit_m(commit_m),
    .commit_n(commit_n), .commit_addr(commit_addr), .commit_err(commit_err),
    .query_slot(query_slot), .query_valid(query_valid), .query_m(query_m),
    .query_n(query_n), .query_addr(query_addr), .num_valid(num_valid), .busy(busy)
  );

  typedef struct packed {
    logic          fail;
    logic [3:0]    slot;
    logic [AW-1:0] addr;
  } resp_t;

  resp_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    mvalid [NS];
  int    mstamp [NS];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; alloc_req = 1'b0; commit_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < NS; i++) begin mvalid[i] = 1'b0; mstamp[i] = 0; end
  endtask

  // Pushes the expected response, then waits a bounded number of edges for it
  task automatic do_alloc(input logic [3:0] m, input logic [3:0] n, input logic ef,
                          input logic [3:0] es, input bit hold);
    resp_t e, got;
    int    k;
    bit    seen;
    e.fail = ef;
    e.slot = ef ? 4'd0 : es;
    e.addr = ef ? '0 : AW'(es * SD);
    exp_q.push_back(e);
    alloc_m = m; alloc_n = n; alloc_req = 1'b1;
    tick();
    k = 0; seen = 1'b0;
    while (!seen && k < 40) begin
      tick(); k++;
      if (k == 5) chk("busy_scan", 32'(busy), 1);
      if (alloc_valid || alloc_fail) seen = 1'b1;
    end
    if (!hold) alloc_req = 1'b0;
    got = exp_q.pop_front();
    if (!seen) begin
      chk("alloc_timeout", 0, 1);
    end else begin
      chk("alloc_latency", k, NS + 2);
      chk("alloc_fail", 32'(alloc_fail), 32'(got.fail));
      chk("alloc_valid", 32'(alloc_valid), 32'(!got.fail));
      if (!got.fail) begin
        chk("alloc_slot", 32'(alloc_slot), 32'(got.slot));
        chk("alloc_addr", 32'(alloc_addr), 32'(got.addr));
      end
    end
    tick();
  endtask

  task automatic do_commit(input logic [3:0] s, input logic [3:0] m, input logic [3:0] n,
                           input int a, input logic eerr, input int enum_v);
    commit_req = 1'b1; commit_slot = s; commit_m = m; commit_n = n; commit_addr = AW'(a);
    tick();
    commit_req = 1'b0;
    chk("commit_err", 32'(commit_err), 32'(eerr));
    tick();
    chk("num_valid", 32'(num_valid), enum_v);
  endtask

  task automatic do_query(input logic [3:0] s, input logic ev, input int em, input int en, input int ea);
    query_slot = s;
    tick();
    chk("query_valid", 32'(query_valid), 32'(ev));
    chk("query_m", 32'(query_m), em);
    chk("query_n", 32'(query_n), en);
    chk("query_addr", 32'(query_addr), ea);
  endtask

  // Free slot first, otherwise the slot committed earliest (limit 1, distinct shapes)
  function automatic int pick_victim();
    int best = 0;
    for (int i = 0; i < NS; i++) if (!mvalid[i]) return i;
    for (int i = 1; i < NS; i++) if (mstamp[i] < mstamp[best]) best = i;
    return best;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, v, s, last_j;
    logic [3:0] m, n;
    config_max_per_shape = 4'd2;
    alloc_m = 4'd0; alloc_n = 4'd0; query_slot = 4'd0;
    commit_slot = 4'd0; commit_m = 4'd0; commit_n = 4'd0; commit_addr = '0;
    do_reset();

    chk("rst_alloc_valid", 32'(alloc_valid), 0);
    chk("rst_alloc_fail", 32'(alloc_fail), 0);
    chk("rst_commit_err", 32'(commit_err), 0);
    chk("rst_num_valid", 32'(num_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_alloc_slot", 32'(alloc_slot), 0);
    chk("rst_alloc_addr", 32'(alloc_addr), 0);
    chk("rst_query_valid", 32'(query_valid), 0);

    // Basic grant, commit, lookup
    do_alloc(4'd2, 4'd3, 1'b0, 4'd0, 1'b0);
    do_commit(4'd0, 4'd2, 4'd3, 0, 1'b0, 1);
    do_query(4'd0, 1'b1, 2, 3, 0);
    do_commit(4'd0, 4'd2, 4'd3, 0, 1'b1, 1);
    do_alloc(4'd3, 4'd3, 1'b0, 4'd1, 1'b0);
    do_commit(4'd1, 4'd3, 4'd4, 25, 1'b1, 1);
    do_commit(4'd1, 4'd3, 4'd3, 25, 1'b0, 2);
    do_query(4'd1, 1'b1, 3, 3, 25);
    do_query(4'd12, 1'b0, 0, 0, 0);

    // Invalid dimensions
    do_alloc(4'd6, 4'd2, 1'b1, 4'd0, 1'b0);
    do_alloc(4'd0, 4'd3, 1'b1, 4'd0, 1'b0);
    do_alloc(4'd2, 4'd6, 1'b1, 4'd0, 1'b0);

    // Per-shape limit of 2
    do_reset();
    config_max_per_shape = 4'd2;
    do_alloc(4'd2, 4'd2, 1'b0, 4'd0, 1'b0);
    do_commit(4'd0, 4'd2, 4'd2, 0, 1'b0, 1);
    do_alloc(4'd2, 4'd2, 1'b0, 4'd1, 1'b0);
    do_commit(4'd1, 4'd2, 4'd2, 25, 1'b0, 2);
`ifdef MATRIX_MGR_EVICT_EN
    do_alloc(4'd2, 4'd2, 1'b0, 4'd0, 1'b0);
    chk("num_after_evict", 32'(num_valid), 1);
    query_slot = 4'd0; tick();
    chk("evicted_invalid", 32'(query_valid), 0);
    do_commit(4'd0, 4'd2, 4'd2, 0, 1'b0, 2);
`else
    do_alloc(4'd2, 4'd2, 1'b1, 4'd0, 1'b0);
    do_query(4'd0, 1'b1, 2, 2, 0);
`endif

    // Request held across a grant; uncommitted reservation is re-granted
    do_reset();
    do_alloc(4'd4, 4'd4, 1'b0, 4'd0, 1'b1);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (alloc_valid || alloc_fail) pulses++;
    end
    chk("held_no_regrant", pulses, 0);
    alloc_req = 1'b0; tick();
    do_alloc(4'd4, 4'd4, 1'b0, 4'd0, 1'b0);

    // Commit during scan, then reset mid-scan
    do_reset();
    alloc_m = 4'd1; alloc_n = 4'd1; alloc_req = 1'b1;
    tick(); tick(); tick(); tick();
    commit_req = 1'b1; commit_slot = 4'd0; commit_m = 4'd1; commit_n = 4'd1; commit_addr = '0;
    tick();
    commit_req = 1'b0;
    chk("commit_in_scan", 32'(commit_err), 1);
    rst = 1'b1; alloc_req = 1'b0;
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (alloc_valid || alloc_fail) pulses++;
    end
    chk("abort_no_pulse", pulses, 0);
    chk("abort_idle", 32'(busy), 0);
    do_alloc(4'd1, 4'd1, 1'b0, 4'd0, 1'b0);

    // Fill with distinct shapes at limit 1, then keep replacing past seq wrap
    do_reset();
    config_max_per_shape = 4'd0;
`ifdef MATRIX_MGR_EVICT_EN
    last_j = 270;
`else
    last_j = NS;
`endif
    for (int j = 0; j < last_j; j++) begin
      s = j % 25;
      m = 4'(s / 5 + 1);
      n = 4'(s % 5 + 1);
      v = pick_victim();
      do_alloc(m, n, 1'b0, 4'(v), 1'b0);
      do_commit(4'(v), m, n, v * SD, 1'b0, (j + 1 < NS) ? j + 1 : NS);
      mvalid[v] = 1'b1;
      mstamp[v] = j;
    end
`ifndef MATRIX_MGR_EVICT_EN
    do_alloc(4'd5, 4'd5, 1'b1, 4'd0, 1'b0);
    chk("full_num_valid", 32'(num_valid), NS);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
